// File: rtl/player_input_checker_pkg.sv
// Shared constants, FSM encoding and key-decoding helpers for the player input checker.
package player_input_checker_pkg;

   localparam logic [1:0] TILE_TL = 2'd0;
   localparam logic [1:0] TILE_TR = 2'd1;
   localparam logic [1:0] TILE_BL = 2'd2;
   localparam logic [1:0] TILE_BR = 2'd3;

   localparam logic [4:0] DIFF_EASY   = 5'd3;
   localparam logic [4:0] DIFF_NORMAL = 5'd6;
   localparam logic [4:0] DIFF_HARD   = 5'd9;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_PENDING = 2'd2,
      S_RELEASE = 2'd3
   } state_e;

   function automatic logic single_bit(input logic [3:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         n += int'(v[i]);
      end
      return (n == 1);
   endfunction

   function automatic logic [1:0] encode_key(input logic [3:0] onehot);
      logic [1:0] code;
      case (onehot)
         4'b0001: code = TILE_TL;
         4'b0010: code = TILE_TR;
         4'b0100: code = TILE_BL;
         4'b1000: code = TILE_BR;
         default: code = TILE_TL;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/player_input_checker_key_sync_edge.sv
// Two-flop synchroniser for the active-low tile keys plus press (1->0) edge detection.
module key_sync_edge (
   input  logic       clock,
   input  logic       resetn,
   input  logic [3:0] keys_i,
   output logic [3:0] sync_o,
   output logic [3:0] press_o
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;
   logic [3:0] prev_q;

   // Preset to all-released so a key held through reset is not seen as a press.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         meta_q <= 4'hF;
         sync_q <= 4'hF;
         prev_q <= 4'hF;
      end else begin
         meta_q <= keys_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o  = sync_q;
   assign press_o = prev_q & ~sync_q;

endmodule

// File: rtl/player_input_checker.sv
// Responder side of the player-turn handshake: records the flashed sequence, captures
// key guesses, answers check strobes and tracks round progress.
module player_input_checker
   import player_input_checker_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int IDX_W   = 5
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [3:0]       keys,
   input  logic             seq_clear,
   input  logic             seq_wr,
   input  logic [1:0]       seq_tile,
   input  logic             round_start,
   input  logic             player_en,
   input  logic             check_en,
   input  logic [4:0]       difficulty,
   output logic             player_input,
   output logic             check,
   output logic [1:0]       guess_tile,
   output logic [1:0]       expected_tile,
   output logic [IDX_W-1:0] seq_len,
   output logic [IDX_W-1:0] rd_idx,
   output logic             round_done,
   output logic             fail,
   output logic             overflow
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int CW = (IDX_W > 5) ? IDX_W : 5;
   localparam logic [IDX_W-1:0] MAX_LEN_W = IDX_W'(MAX_LEN);

   state_e           state_q, state_d;
   logic [1:0]       guess_q, guess_d;
   logic [IDX_W-1:0] seq_len_q, seq_len_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic             fail_q, fail_d;
   logic             overflow_q, overflow_d;
   logic [1:0]       mem_q [MAX_LEN];

   logic [3:0]       keys_sync;
   logic [3:0]       press;
   logic             single_press;
   logic             consume;
   logic             wr_ok;
   logic             rd_in_range;
   logic [1:0]       rd_tile;
   logic             done;
   logic             match;

   key_sync_edge u_key_sync_edge (
      .clock   (clock),
      .resetn  (resetn),
      .keys_i  (keys),
      .sync_o  (keys_sync),
      .press_o (press)
   );

   // Sequence memory: a clear in the same cycle drops the write.
   assign wr_ok = seq_wr && !seq_clear && (seq_len_q != MAX_LEN_W);

   always_ff @(posedge clock) begin
      if (wr_ok) begin
         mem_q[seq_len_q[AW-1:0]] <= seq_tile;
      end
   end

   always_comb begin
      seq_len_d  = seq_len_q;
      overflow_d = overflow_q;
      if (seq_clear) begin
         seq_len_d  = '0;
         overflow_d = 1'b0;
      end else if (seq_wr) begin
         if (seq_len_q == MAX_LEN_W) begin
            overflow_d = 1'b1;
         end else begin
            seq_len_d = seq_len_q + IDX_W'(1);
         end
      end
   end

   assign rd_in_range = (rd_idx_q < seq_len_q);

   always_comb begin
      rd_tile = 2'd0;
      if (rd_in_range) begin
         rd_tile = mem_q[rd_idx_q[AW-1:0]];
      end
   end

   assign done  = (CW'(rd_idx_q) == CW'(difficulty)) && (difficulty != 5'd0);
   assign match = rd_in_range && (guess_q == rd_tile);

   // A guess is accepted only when exactly one key goes down and every other key is up.
   assign single_press = single_bit(press) && (keys_sync == ~press);

   always_comb begin
      state_d = state_q;
      guess_d = guess_q;
      consume = 1'b0;
      if (!player_en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_ARMED;
            end
            S_ARMED: begin
               if (single_press) begin
                  guess_d = encode_key(press);
                  state_d = S_PENDING;
               end
            end
            S_PENDING: begin
               if (check_en) begin
                  consume = 1'b1;
                  state_d = S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (keys_sync == 4'hF) begin
                  state_d = S_ARMED;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // round_start outranks a same-cycle consume; seq_clear outranks an increment.
   always_comb begin
      rd_idx_d = rd_idx_q;
      fail_d   = fail_q;
      if (round_start) begin
         rd_idx_d = '0;
         fail_d   = 1'b0;
      end else begin
         if (consume && !done) begin
            if (match) begin
               rd_idx_d = rd_idx_q + IDX_W'(1);
            end else begin
               fail_d = 1'b1;
            end
         end
         if (seq_clear) begin
            rd_idx_d = '0;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         guess_q    <= 2'd0;
         seq_len_q  <= '0;
         rd_idx_q   <= '0;
         fail_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         guess_q    <= guess_d;
         seq_len_q  <= seq_len_d;
         rd_idx_q   <= rd_idx_d;
         fail_q     <= fail_d;
         overflow_q <= overflow_d;
      end
   end

   assign player_input  = (state_q == S_PENDING);
   assign check         = player_input && match;
   assign guess_tile    = guess_q;
   assign expected_tile = rd_tile;
   assign seq_len       = seq_len_q;
   assign rd_idx        = rd_idx_q;
   assign round_done    = done;
   assign fail          = fail_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_player_input_checker.sv
// Self-checking bench for player_input_checker: directed tables, corner sequences and
// randomized rounds against a transaction-level model.
module tb_player_input_checker;
   import player_input_checker_pkg::*;

   localparam int MAX_LEN = 16;
   localparam int IDX_W   = 5;

   logic             clock = 1'b0;
   logic             resetn;
   logic [3:0]       keys;
   logic             seq_clear, seq_wr, round_start, player_en, check_en;
   logic [1:0]       seq_tile;
   logic [4:0]       difficulty;
   logic             player_input, check, round_done, fail, overflow;
   logic [1:0]       guess_tile, expected_tile;
   logic [IDX_W-1:0] seq_len, rd_idx;

   int checks   = 0;
   int failures = 0;

   player_input_checker #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .keys          (keys),
      .seq_clear     (seq_clear),
      .seq_wr        (seq_wr),
      .seq_tile      (seq_tile),
      .round_start   (round_start),
      .player_en     (player_en),
      .check_en      (check_en),
      .difficulty    (difficulty),
      .player_input  (player_input),
      .check         (check),
      .guess_tile    (guess_tile),
      .expected_tile (expected_tile),
      .seq_len       (seq_len),
      .rd_idx        (rd_idx),
      .round_done    (round_done),
      .fail          (fail),
      .overflow      (overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      int   tile;
      logic exp_check;
      int   exp_rd;
      logic exp_done;
   } guess_vec_t;

   typedef struct {
      logic [3:0] pattern;
      logic       exp_pend;
      int         exp_guess;
   } multi_vec_t;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_pend(input string name);
      int n;
      n = 0;
      while (!player_input && n < 10) begin
         tick();
         n++;
      end
      chk(name, int'(player_input), 1);
   endtask

   task automatic press(input int k);
      keys    = 4'hF;
      keys[k] = 1'b0;
   endtask

   task automatic consume();
      check_en = 1'b1;
      tick();
      check_en = 1'b0;
   endtask

   task automatic release_keys();
      keys = 4'hF;
      repeat (4) tick();
   endtask

   task automatic clear_seq();
      seq_clear = 1'b1;
      tick();
      seq_clear = 1'b0;
   endtask

   task automatic write_tile(input int t);
      seq_tile = 2'(t);
      seq_wr   = 1'b1;
      tick();
      seq_wr   = 1'b0;
   endtask

   task automatic start_round(input int d);
      difficulty  = 5'(d);
      round_start = 1'b1;
      tick();
      round_start = 1'b0;
   endtask

   guess_vec_t gv[3];
   multi_vec_t mv[4];
   logic [1:0] q[$];

   initial begin
      int rises;
      logic prev_pi;
      int len, diff, rd, key, exp_tile;
      logic mfail, correct;

      resetn = 1'b0; keys = 4'hF; seq_clear = 0; seq_wr = 0; seq_tile = 0;
      round_start = 0; player_en = 0; check_en = 0; difficulty = 0;
      repeat (3) tick();
      chk("reset_player_input", int'(player_input), 0);
      chk("reset_seq_len", int'(seq_len), 0);
      chk("reset_rd_idx", int'(rd_idx), 0);
      chk("reset_fail", int'(fail), 0);
      chk("reset_overflow", int'(overflow), 0);
      resetn = 1'b1;
      tick();
      player_en = 1'b1;
      tick();

      // Correct three-guess round with an exact latency check on the first guess.
      gv[0] = '{3, 1'b1, 1, 1'b0};
      gv[1] = '{1, 1'b1, 2, 1'b0};
      gv[2] = '{2, 1'b1, 3, 1'b1};
      clear_seq();
      write_tile(3); write_tile(1); write_tile(2);
      chk("seq_len_3", int'(seq_len), 3);
      start_round(int'(DIFF_EASY));
      press(3);
      tick(); tick();
      chk("latency_2cyc", int'(player_input), 0);
      tick();
      chk("latency_3cyc", int'(player_input), 1);
      for (int i = 0; i < 3; i++) begin
         if (i != 0) begin
            press(gv[i].tile);
            wait_pend($sformatf("g%0d_pend", i));
         end
         chk($sformatf("g%0d_guess", i), int'(guess_tile), gv[i].tile);
         chk($sformatf("g%0d_check", i), int'(check), int'(gv[i].exp_check));
         consume();
         chk($sformatf("g%0d_pi_drop", i), int'(player_input), 0);
         chk($sformatf("g%0d_rd", i), int'(rd_idx), gv[i].exp_rd);
         chk($sformatf("g%0d_done", i), int'(round_done), int'(gv[i].exp_done));
         chk($sformatf("g%0d_fail", i), int'(fail), 0);
         release_keys();
      end
      press(3);
      wait_pend("sat_pend");
      chk("sat_exp_tile", int'(expected_tile), 0);
      chk("sat_check", int'(check), 0);
      consume();
      chk("sat_rd", int'(rd_idx), 3);
      chk("sat_fail", int'(fail), 0);
      release_keys();

      // Wrong guess sets fail and leaves rd_idx.
      clear_seq();
      write_tile(0); write_tile(2);
      start_round(2);
      press(1);
      wait_pend("wrong_pend");
      chk("wrong_exp_tile", int'(expected_tile), 0);
      chk("wrong_check", int'(check), 0);
      chk("wrong_guess", int'(guess_tile), 1);
      consume();
      chk("wrong_fail", int'(fail), 1);
      chk("wrong_rd", int'(rd_idx), 0);
      release_keys();

      // A held key yields exactly one guess.
      start_round(2);
      press(2);
      rises = 0;
      prev_pi = player_input;
      for (int i = 0; i < 50; i++) begin
         check_en = 1'(i % 2);
         tick();
         if (player_input && !prev_pi) rises++;
         prev_pi = player_input;
      end
      check_en = 1'b0;
      chk("hold_one_guess", rises, 1);
      release_keys();
      press(2);
      wait_pend("hold_second_guess");
      consume();
      release_keys();

      // Simultaneous presses are rejected, single presses accepted.
      mv[0] = '{4'b0110, 1'b0, 0};
      mv[1] = '{4'b1110, 1'b1, 0};
      mv[2] = '{4'b0111, 1'b1, 3};
      mv[3] = '{4'b1001, 1'b0, 0};
      for (int i = 0; i < 4; i++) begin
         keys = mv[i].pattern;
         repeat (6) tick();
         chk($sformatf("multi%0d_pend", i), int'(player_input), int'(mv[i].exp_pend));
         if (mv[i].exp_pend) begin
            chk($sformatf("multi%0d_guess", i), int'(guess_tile), mv[i].exp_guess);
            consume();
         end
         release_keys();
      end

      // player_en drop discards a pending guess.
      clear_seq();
      write_tile(1); write_tile(1);
      start_round(2);
      press(1);
      wait_pend("disc_pend");
      player_en = 1'b0;
      check_en  = 1'b1;
      tick();
      check_en  = 1'b0;
      chk("disc_pi", int'(player_input), 0);
      chk("disc_rd", int'(rd_idx), 0);
      chk("disc_fail", int'(fail), 0);
      player_en = 1'b1;
      release_keys();

      // round_start beats a same-cycle consume.
      press(1);
      wait_pend("rs_pend");
      chk("rs_check", int'(check), 1);
      check_en = 1'b1; round_start = 1'b1;
      tick();
      check_en = 1'b0; round_start = 1'b0;
      chk("rs_rd", int'(rd_idx), 0);
      chk("rs_pi", int'(player_input), 0);
      release_keys();

      // Overflow and clear-beats-write.
      clear_seq();
      for (int i = 0; i < 17; i++) write_tile(i % 4);
      chk("ovf_len", int'(seq_len), 16);
      chk("ovf_flag", int'(overflow), 1);
      seq_clear = 1'b1; seq_wr = 1'b1;
      tick();
      seq_clear = 1'b0; seq_wr = 1'b0;
      chk("clr_len", int'(seq_len), 0);
      chk("clr_ovf", int'(overflow), 0);

      // Randomized rounds against a transaction-level model.
      for (int r = 0; r < 6; r++) begin
         clear_seq();
         q.delete();
         len = int'($urandom_range(1, 8));
         for (int i = 0; i < len; i++) begin
            q.push_back(2'($urandom_range(0, 3)));
            write_tile(int'(q[i]));
         end
         diff = int'($urandom_range(1, len));
         start_round(diff);
         rd = 0; mfail = 1'b0;
         for (int g = 0; g <= diff; g++) begin
            if (rd < len && $urandom_range(0, 3) != 0) key = int'(q[rd]);
            else key = int'($urandom_range(0, 3));
            exp_tile = (rd < len) ? int'(q[rd]) : 0;
            correct  = (rd < len) && (key == exp_tile);
            press(key);
            wait_pend($sformatf("rnd%0d_%0d_pend", r, g));
            chk($sformatf("rnd%0d_%0d_guess", r, g), int'(guess_tile), key);
            chk($sformatf("rnd%0d_%0d_exp", r, g), int'(expected_tile), exp_tile);
            chk($sformatf("rnd%0d_%0d_check", r, g), int'(check), int'(correct));
            consume();
            if (rd != diff) begin
               if (correct) rd++;
               else mfail = 1'b1;
            end
            chk($sformatf("rnd%0d_%0d_rd", r, g), int'(rd_idx), rd);
            chk($sformatf("rnd%0d_%0d_fail", r, g), int'(fail), int'(mfail));
            chk($sformatf("rnd%0d_%0d_done", r, g), int'(round_done), int'(rd == diff));
            release_keys();
         end
      end

      // Asynchronous reset while a guess is pending.
      clear_seq();
      write_tile(0);
      start_round(1);
      press(0);
      wait_pend("ar_pend");
      keys = 4'hF;
      @(posedge clock);
      #3;
      resetn = 1'b0;
      #1;
      chk("ar_pi", int'(player_input), 0);
      chk("ar_check", int'(check), 0);
      chk("ar_rd", int'(rd_idx), 0);
      chk("ar_fail", int'(fail), 0);
      chk("ar_len", int'(seq_len), 0);
      tick();
      resetn = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
